test_mem_req_adapter: RTL

TEST_MEM_REQ_ADAPTER -- requirements
Module: test_mem_req_adapter

---
 rtl/test_mem_req_adapter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/test_mem_req_adapter.sv
// test_mem_req_adapter
// Bridges a valid/ready request stream onto a synchronous test memory that
// has separate read and write ports. Responses come back through a small
// in-order buffer. Read data arrives one cycle after the read strobe.
// A request may be accepted only when the buffer has room for every
// response that is already in flight, so the buffer can never overflow.
module test_mem_req_adapter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int RESP_DEPTH = 3    // must be >= 3 to sustain one request per cycle
) (
    input  logic            clk,
    input  logic            reset,          // asynchronous, active-low

    input  logic            req_val,
    output logic            req_rdy,
    input  logic            req_type,       // 0 = read, 1 = write
    input  logic [AW+1:0]   req_addr,       // byte address
    input  logic [DW-1:0]   req_data,

    output logic            resp_val,
    input  logic            resp_rdy,
    output logic            resp_type,
    output logic [DW-1:0]   resp_data,

    output logic            mem_read_en,
    output logic [AW-1:0]   mem_read_addr,
    input  logic [DW-1:0]   mem_read_data,

    output logic            mem_write_en,
    output logic [AW-1:0]   mem_write_addr,
    output logic [DW-1:0]   mem_write_data
);

    localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CW = $clog2(RESP_DEPTH + 1);

    localparam logic [PW-1:0] LAST_PTR = PW'(RESP_DEPTH - 1);
    localparam logic [CW:0]   DEPTH_L  = (CW+1)'(RESP_DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(RESP_DEPTH);

    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } req_type_e;

    typedef struct packed {
        logic          rtype;
        logic [DW-1:0] data;
    } resp_entry_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic              s1_val_q;
    logic              s1_type_q;

    logic [CW-1:0]     count_q,  count_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;

    resp_entry_t       resp_mem_q [RESP_DEPTH];

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------
    logic              fire;
    logic [AW-1:0]     word_addr;
    logic [CW:0]       level;
    logic              unused_addr_bits;

    // Byte-lane bits are dropped silently; the memory is word addressed.
    assign word_addr        = req_addr[AW+1:2];
    assign unused_addr_bits = ^req_addr[1:0];

    // Responses already committed: buffered entries plus the one in stage 1.
    // Built from registers only, so resp_rdy/req_val never reach req_rdy.
    // Holding reset low forces req_rdy low, which also masks both strobes.
    assign level   = {1'b0, count_q} + {{CW{1'b0}}, s1_val_q};
    assign req_rdy = reset & (level < DEPTH_L);
    assign fire    = req_val & req_rdy;

    assign mem_read_en    = fire & (req_type_e'(req_type) == REQ_READ);
    assign mem_read_addr  = word_addr;
    assign mem_write_en   = fire & (req_type_e'(req_type) == REQ_WRITE);
    assign mem_write_addr = word_addr;
    assign mem_write_data = req_data;

    // Stage 1 tracks the request whose memory access is in progress.
    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values, independent of the order the always blocks run in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_val_q  <= 1'b0;
            s1_type_q <= 1'b0;
        end else begin
            s1_val_q  <= fire;
            if (fire) begin
                s1_type_q <= req_type;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response buffer
    // ------------------------------------------------------------------
    logic              push;
    logic              pop;
    resp_entry_t       push_entry;
    resp_entry_t       head_entry;

    assign push = s1_val_q;
    assign pop  = resp_val & resp_rdy;

    // Build the entry to enqueue; read data is looked at only for a read in stage 1.
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        push_entry       = '0;
        push_entry.rtype = s1_type_q;
        if (s1_val_q && (req_type_e'(s1_type_q) == REQ_READ)) begin
            push_entry.data = mem_read_data;
        end
    end

    // Next pointer and occupancy values; pointers wrap at RESP_DEPTH, not at a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;   // idle, or enqueue and pop together
        endcase
    end

    // Buffer control registers; reset discards every buffered response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Buffer storage written at the tail.
    // NOTE: the storage array has no reset; validity comes from count_q and
    // the outputs are masked when the buffer is empty, so stale contents
    // are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            resp_mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // The head entry drives the response port; zeros are shown when nothing is held.
    assign head_entry = resp_mem_q[rd_ptr_q];
    assign resp_val   = (count_q != '0);
    assign resp_type  = resp_val & head_entry.rtype;
    assign resp_data  = resp_val ? head_entry.data : '0;

    // Occupancy can never go above the buffer size, because of how req_rdy is built.
    always_ff @(posedge clk) begin
        if (reset) begin
            assert (count_q <= FULL_CNT);
        end
    end

endmodule
